vector_xbar_mapper: RTL and testbench

VECTOR_XBAR_MAPPER -- requirements
Module: vector_xbar_mapper

---
 rtl/vector_xbar_mapper.sv | 141 ++++++++++++++
 tb/tb_vector_xbar_mapper.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_xbar_mapper.sv
// Vector crossbar mapper: captures a batch of per-lane source selections and
// issues the mapped data as one beat (BCAST/FIRST) or as several beats (SERIAL).
module vector_xbar_mapper #(
  parameter int unsigned NUM_PORT   = 8,
  parameter int unsigned DATA_WIDTH = 64,
  localparam int unsigned IDX_W     = (NUM_PORT <= 2) ? 1 : $clog2(NUM_PORT)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [1:0]                     in_mode,
  input  logic [NUM_PORT-1:0]            in_lane_vld,
  input  logic [NUM_PORT*IDX_W-1:0]      in_src,
  input  logic [NUM_PORT*DATA_WIDTH-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_PORT-1:0]            out_lane_vld,
  output logic [NUM_PORT*DATA_WIDTH-1:0] out_data,
  output logic                           out_last,
  output logic                           out_conflict,
  output logic [IDX_W-1:0]               out_beat
);

  localparam logic [1:0] MODE_FIRST  = 2'b01;
  localparam logic [1:0] MODE_SERIAL = 2'b10;

  typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [1:0]              r_mode;
  logic [IDX_W-1:0]        r_src  [NUM_PORT];
  logic [DATA_WIDTH-1:0]   r_data [NUM_PORT];
  logic [NUM_PORT-1:0]     r_pend;
  logic                    r_conflict;
  logic [IDX_W-1:0]        r_beat;

  logic [NUM_PORT-1:0]     w_in_req;
  logic                    w_in_conflict;
  logic [NUM_PORT-1:0]     w_first;
  logic [NUM_PORT-1:0]     w_served;
  logic                    w_accept;
  logic                    w_fire;

  // Source index is usable only when it names an existing lane.
  function automatic logic src_ok(input int unsigned s);
    return s < NUM_PORT;
  endfunction

  // Classify incoming lanes: drop out-of-range sources, detect shared or bad sources.
  always_comb begin
    w_in_req      = '0;
    w_in_conflict = 1'b0;
    for (int i = 0; i < NUM_PORT; i++) begin
      w_in_req[i] = in_lane_vld[i] && src_ok(32'(in_src[i*IDX_W +: IDX_W]));
      if (in_lane_vld[i] && !w_in_req[i]) w_in_conflict = 1'b1;
    end
    for (int i = 0; i < NUM_PORT; i++) begin
      for (int j = 0; j < i; j++) begin
        if (w_in_req[i] && w_in_req[j] &&
            (in_src[i*IDX_W +: IDX_W] == in_src[j*IDX_W +: IDX_W]))
          w_in_conflict = 1'b1;
      end
    end
  end

  // Per source, keep only the lowest-index pending lane claiming it.
  always_comb begin
    w_first = r_pend;
    for (int i = 0; i < NUM_PORT; i++) begin
      for (int j = 0; j < i; j++) begin
        if (r_pend[j] && (r_src[j] == r_src[i])) w_first[i] = 1'b0;
      end
    end
    w_served = ((r_mode == MODE_FIRST) || (r_mode == MODE_SERIAL)) ? w_first : r_pend;
  end

  // Output beat formed from the captured batch; unserved lanes read as zero.
  always_comb begin
    out_valid    = (r_state == ST_ISSUE);
    out_lane_vld = out_valid ? w_served : '0;
    out_last     = out_valid && ((r_mode != MODE_SERIAL) || ((r_pend & ~w_served) == '0));
    out_conflict = r_conflict;
    out_beat     = r_beat;
    out_data     = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      if (out_lane_vld[i]) out_data[i*DATA_WIDTH +: DATA_WIDTH] = r_data[r_src[i]];
    end
    w_fire   = out_valid && out_ready;
    in_ready = (r_state == ST_IDLE) || (w_fire && out_last);
    w_accept = in_valid && in_ready;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state: a new batch may be taken on the final beat without an idle gap.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (in_valid) w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (w_fire && out_last) w_state_nxt = in_valid ? ST_ISSUE : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Batch capture and per-beat pending-mask / beat-counter update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode     <= 2'b00;
      r_pend     <= '0;
      r_conflict <= 1'b0;
      r_beat     <= '0;
      for (int i = 0; i < NUM_PORT; i++) begin
        r_src[i]  <= '0;
        r_data[i] <= '0;
      end
    end else if (w_accept) begin
      r_mode     <= in_mode;
      r_pend     <= w_in_req;
      r_conflict <= w_in_conflict;
      r_beat     <= '0;
      for (int i = 0; i < NUM_PORT; i++) begin
        r_src[i]  <= in_src[i*IDX_W +: IDX_W];
        r_data[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if (w_fire) begin
      if (out_last) begin
        r_pend <= '0;
      end else begin
        r_pend <= r_pend & ~w_served;
        r_beat <= r_beat + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vector_xbar_mapper.sv
// Directed bench for vector_xbar_mapper with a batch-level reference model.
module tb_vector_xbar_mapper;

  localparam int unsigned NP = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned IW = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_mode;
  logic [NP-1:0]      in_lane_vld;
  logic [NP*IW-1:0]   in_src;
  logic [NP*DW-1:0]   in_data;
  logic               out_valid;
  logic               out_ready;
  logic [NP-1:0]      out_lane_vld;
  logic [NP*DW-1:0]   out_data;
  logic               out_last;
  logic               out_conflict;
  logic [IW-1:0]      out_beat;

  vector_xbar_mapper #(.NUM_PORT(NP), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_lane_vld(in_lane_vld), .in_src(in_src), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane_vld(out_lane_vld),
    .out_data(out_data), .out_last(out_last), .out_conflict(out_conflict),
    .out_beat(out_beat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NP-1:0]    lv;
    logic [NP*DW-1:0] data;
    logic             last;
    logic             conf;
    logic [IW-1:0]    beat;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [NP*DW-1:0] DATA0 = 32'h2c21160b;  // lanes 3..0 = 44,33,22,11

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: group requested lanes by source, then hand claimants out per beat.
  function automatic void model(input logic [1:0] mode, input logic [NP-1:0] lv,
                                input logic [NP*IW-1:0] src, input logic [NP*DW-1:0] data);
    int   claim [NP][NP];
    int   ncl [NP];
    int   nb;
    int   lo;
    int   hi;
    logic conf;
    exp_t e;
    for (int s = 0; s < NP; s++) ncl[s] = 0;
    for (int i = 0; i < NP; i++) begin
      if (lv[i]) begin
        int s;
        s = int'(src[i*IW +: IW]);
        claim[s][ncl[s]] = i;
        ncl[s]++;
      end
    end
    conf = 1'b0;
    nb   = 1;
    for (int s = 0; s < NP; s++) begin
      if (ncl[s] > 1) conf = 1'b1;
      if (mode == 2'b10 && ncl[s] > nb) nb = ncl[s];
    end
    for (int k = 0; k < nb; k++) begin
      e.lv   = '0;
      e.data = '0;
      for (int s = 0; s < NP; s++) begin
        if (mode == 2'b01)      begin lo = 0; hi = (ncl[s] > 0) ? 1 : 0; end
        else if (mode == 2'b10) begin lo = k; hi = (ncl[s] > k) ? k + 1 : k; end
        else                    begin lo = 0; hi = ncl[s]; end
        for (int c = lo; c < hi; c++) begin
          e.lv[claim[s][c]] = 1'b1;
          e.data[claim[s][c]*DW +: DW] = data[s*DW +: DW];
        end
      end
      e.last = (k == nb - 1);
      e.conf = conf;
      e.beat = IW'(k);
      exp_q.push_back(e);
    end
  endfunction

  // Every cycle a beat is offered, it must equal the model's head beat.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 64'(out_valid), 64'(0));
      end else begin
        cur = exp_q[0];
        check("lane_vld", 64'(out_lane_vld), 64'(cur.lv));
        check("data",     64'(out_data),     64'(cur.data));
        check("last",     64'(out_last),     64'(cur.last));
        check("conflict", 64'(out_conflict), 64'(cur.conf));
        check("beat",     64'(out_beat),     64'(cur.beat));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Offer one batch and hold it until accepted; returns one step after the accepting edge.
  task automatic send(input logic [1:0] mode, input logic [NP-1:0] lv,
                      input logic [NP*IW-1:0] src, input logic [NP*DW-1:0] data);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    in_mode = mode; in_lane_vld = lv; in_src = src; in_data = data; in_valid = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (in_ready) begin
        model(mode, lv, src, data);
        ok = 1'b1;
      end
    end
    if (!ok) check("accept_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_lane_vld = '0; in_src = '0; in_data = '0; in_mode = '0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
    end
    if (!done) check("drain_timeout", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic wait_beat(input logic [IW-1:0] b);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(posedge clk); #1;
      if (out_valid && out_beat == b) seen = 1'b1;
    end
    if (!seen) check("beat_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_mode = '0; in_lane_vld = '0; in_src = '0; in_data = '0;
    #1;
    check("rst_out_valid",  64'(out_valid),    64'(0));
    check("rst_lane_vld",   64'(out_lane_vld), 64'(0));
    check("rst_data",       64'(out_data),     64'(0));
    check("rst_last",       64'(out_last),     64'(0));
    check("rst_conflict",   64'(out_conflict), 64'(0));
    check("rst_beat",       64'(out_beat),     64'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_in_ready",   64'(in_ready),     64'(1));

    // BCAST, lane i sources lane 3-i
    send(2'b00, 4'b1111, 8'h1B, DATA0);
    check("bcast_data",     64'(out_data),     64'h0b16212c);
    check("bcast_lv",       64'(out_lane_vld), 64'hf);
    check("bcast_last",     64'(out_last),     64'(1));
    check("bcast_conf",     64'(out_conflict), 64'(0));
    check("bcast_beat",     64'(out_beat),     64'(0));
    drain();

    // FIRST, all lanes on source 2
    send(2'b01, 4'b1111, 8'hAA, DATA0);
    check("first_data",     64'(out_data),     64'h21);
    check("first_lv",       64'(out_lane_vld), 64'h1);
    check("first_conf",     64'(out_conflict), 64'(1));
    check("first_last",     64'(out_last),     64'(1));
    drain();

    // SERIAL, all lanes on source 2: four single-lane beats
    send(2'b10, 4'b1111, 8'hAA, DATA0);
    for (int k = 0; k < 4; k++) begin
      check("ser_lv",   64'(out_lane_vld), 64'(1) << k);
      check("ser_data", 64'(out_data),     64'h21 << (8 * k));
      check("ser_beat", 64'(out_beat),     64'(k));
      check("ser_last", 64'(out_last),     64'(k == 3));
      @(posedge clk); #1;
    end
    drain();

    // SERIAL with stall on beat 1, next batch offered during final beat
    send(2'b10, 4'b1111, 8'hAA, DATA0);
    wait_beat(2'd1);
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    send(2'b00, 4'b1111, 8'h1B, DATA0);
    check("b2b_valid",      64'(out_valid),    64'(1));
    check("b2b_beat",       64'(out_beat),     64'(0));
    check("b2b_data",       64'(out_data),     64'h0b16212c);
    drain();

    // Reset during beat 1 of a 4-beat SERIAL batch
    send(2'b10, 4'b1111, 8'hAA, DATA0);
    @(posedge clk); #1;
    check("pre_rst_beat",   64'(out_beat),     64'(1));
    reset = 1'b1;
    #1;
    check("midrst_valid",   64'(out_valid),    64'(0));
    check("midrst_lv",      64'(out_lane_vld), 64'(0));
    check("midrst_data",    64'(out_data),     64'(0));
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    check("postrst_ready",  64'(in_ready),     64'(1));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("postrst_idle", 64'(out_valid),    64'(0));
    end

    // Empty batch still issues one terminal beat
    send(2'b10, 4'b0000, 8'h1B, DATA0);
    check("empty_lv",       64'(out_lane_vld), 64'(0));
    check("empty_data",     64'(out_data),     64'(0));
    check("empty_last",     64'(out_last),     64'(1));
    drain();

    // Mixed patterns covered by the model
    send(2'b10, 4'b1011, 8'h45, 32'hA5C37E19);
    drain();
    send(2'b01, 4'b1111, 8'hCC, 32'hA5C37E19);
    drain();
    send(2'b11, 4'b0110, 8'h1B, 32'hA5C37E19);
    drain();
    send(2'b10, 4'b1110, 8'h05, 32'h0F1E2D3C);
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
